// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multi-cycle MIPS core's memory port.
// A read/write request sampled in IDLE is served from a word-addressed RAM
// LATENCY edges later (the accept edge counts as the first), then answered with
// a one-cycle ready pulse. Requests arriving while busy are ignored.
// Optional feature macro: MEM_BYTE_STROBE_EN (adds wstrb byte-enable input).
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   mem_read        read request (level-sampled in IDLE)
//   mem_write       write request (level-sampled in IDLE)
//   addr[31:0]      byte address; bits above ADDR_W+1 ignored (aliasing)
//   wdata[31:0]     store data
//   wstrb[3:0]      byte enables (only with MEM_BYTE_STROBE_EN)
//   rdata[31:0]     read data, valid with ready, held until next response
//   ready           one-cycle response pulse
//   busy            high from acceptance edge until the end of the ready cycle
//   addr_err        high with ready when the request was rejected
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [3:0]  wstrb,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam int         DEPTH  = 1 << ADDR_W;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_rd;
  logic                r_wr;
  logic                r_err;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [DEPTH];

  logic                w_accept;
  logic                w_commit;
  logic                w_from_idle;
  logic [ADDR_W+1:0]   w_c_addr;
  logic [31:0]         w_c_wdata;
  logic [3:0]          w_c_strb;
  logic                w_c_rd;
  logic                w_c_wr;
  logic                w_c_err;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_unused_addr;

  assign w_accept    = (r_state == S_IDLE) && (mem_read || mem_write);
  assign w_commit    = (w_next == S_RESP) && (r_state != S_RESP);

  // With LATENCY=1 the commit happens on the accept edge itself, so the
  // request must come straight from the inputs rather than the latches.
  assign w_from_idle = (r_state == S_IDLE);
  assign w_c_addr    = w_from_idle ? addr[ADDR_W+1:0] : r_addr;
  assign w_c_wdata   = w_from_idle ? wdata : r_wdata;
  assign w_c_rd      = w_from_idle ? mem_read : r_rd;
  assign w_c_wr      = w_from_idle ? mem_write : r_wr;

`ifdef MEM_BYTE_STROBE_EN
  logic [3:0] r_strb;
  assign w_c_strb = w_from_idle ? wstrb : r_strb;
`else
  assign w_c_strb = 4'hF;
`endif

  assign w_c_err       = (w_c_addr[1:0] != 2'b00) || (w_c_rd && w_c_wr);
  assign w_idx         = w_c_addr[ADDR_W+1:2];
  // Upper address bits are intentionally dropped: the RAM aliases.
  assign w_unused_addr = ^addr[31:ADDR_W+2];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready    = (r_state == S_RESP);
    busy     = (r_state != S_IDLE);
    addr_err = (r_state == S_RESP) && r_err;
  end

  assign rdata = r_rdata;

  // Request latches, latency counter and response data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
`ifdef MEM_BYTE_STROBE_EN
      r_strb  <= 4'd0;
`endif
    end else begin
      if (w_accept) begin
        r_addr  <= addr[ADDR_W+1:0];
        r_wdata <= wdata;
        r_rd    <= mem_read;
        r_wr    <= mem_write;
        r_cnt   <= LAT_M1;
`ifdef MEM_BYTE_STROBE_EN
        r_strb  <= wstrb;
`endif
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err <= w_c_err;
        if (w_c_err)     r_rdata <= 32'd0;
        else if (w_c_rd) r_rdata <= r_mem[w_idx];
      end
    end
  end

  // RAM write port; contents survive reset, and a reset on the commit edge
  // abandons the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_c_wr && !w_c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_c_strb[i]) r_mem[w_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Three responders (LATENCY 2, 1, 5) share one request stream; each has its
// own expected-response queue, drained by a monitor on every ready pulse.
module tb_mem_responder;

  localparam int L0 = 2;
  localparam int L1 = 1;
  localparam int L2 = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
`ifdef MEM_BYTE_STROBE_EN
  logic [3:0]  wstrb = 4'hF;
`endif
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        busy [3];
  logic        addr_err [3];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] mdl_mem [3][1024];
  logic [31:0] mdl_rd [3];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_W(10), .LATENCY(L0)) u_l2 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_STROBE_EN
    .wstrb(wstrb),
`endif
    .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .addr_err(addr_err[0]));

  mem_responder #(.ADDR_W(10), .LATENCY(L1)) u_l1 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_STROBE_EN
    .wstrb(wstrb),
`endif
    .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .addr_err(addr_err[1]));

  mem_responder #(.ADDR_W(10), .LATENCY(L2)) u_l5 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_STROBE_EN
    .wstrb(wstrb),
`endif
    .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]), .addr_err(addr_err[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return L0;
      1:       return L1;
      default: return L2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model for one accepted request on DUT d; pushes its response.
  task automatic expect_req(input int d, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input int acc);
    exp_t       e;
    logic [9:0] idx;
    idx   = a[11:2];
    e.err = (a[1:0] != 2'b00) || (rd && wr);
    if (e.err) begin
      mdl_rd[d] = 32'd0;
    end else if (wr) begin
      for (int i = 0; i < 4; i++)
        if (st[i]) mdl_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
    end else begin
      mdl_rd[d] = mdl_mem[d][idx];
    end
    e.rdata = mdl_rd[d];
    e.acc   = acc;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int d, output exp_t e, output bit ok);
    ok = 1'b1;
    e  = '{rdata: 32'd0, err: 1'b0, acc: 0};
    case (d)
      0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Monitor: every ready pulse must match the head of that DUT's queue,
  // including the number of edges from acceptance (accept edge counted).
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    for (int d = 0; d < 3; d++) begin
      if (ready[d]) begin
        pop_exp(d, e, ok);
        if (!ok) check($sformatf("unexpected_ready[%0d]", d), 32'd1, 32'd0);
        else begin
          check($sformatf("rdata[%0d]", d), rdata[d], e.rdata);
          check($sformatf("addr_err[%0d]", d), {31'd0, addr_err[d]}, {31'd0, e.err});
          check($sformatf("latency[%0d]", d), 32'(cyc - e.acc + 1), 32'(lat_of(d)));
        end
      end else if (addr_err[d]) begin
        check($sformatf("addr_err_without_ready[%0d]", d), 32'd1, 32'd0);
      end
    end
  end

  // One request held for exactly one rising edge. With abort set, only the
  // LATENCY=1 responder commits before the reset that follows.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st, input bit abort);
    int acc;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
`ifdef MEM_BYTE_STROBE_EN
    wstrb     = st;
`endif
    acc = cyc + 1;
    for (int d = 0; d < 3; d++)
      if (!abort || lat_of(d) == 1) expect_req(d, rd, wr, a, wd, st, acc);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic wait_idle(input bit chk);
    int bc[3];
    bit done;
    bc   = '{0, 0, 0};
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (busy[d]) bc[d]++;
      if (!busy[0] && !busy[1] && !busy[2]) done = 1'b1;
    end
    check("idle_reached", {31'd0, done}, 32'd1);
    if (chk)
      for (int d = 0; d < 3; d++)
        check($sformatf("busy_cycles[%0d]", d), 32'(bc[d]), 32'(lat_of(d)));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int acc;
    for (int d = 0; d < 3; d++) mdl_rd[d] = 32'd0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_rdata[%0d]", d), rdata[d], 32'd0);
      check($sformatf("rst_ready[%0d]", d), {31'd0, ready[d]}, 32'd0);
      check($sformatf("rst_busy[%0d]", d), {31'd0, busy[d]}, 32'd0);
      check($sformatf("rst_err[%0d]", d), {31'd0, addr_err[d]}, 32'd0);
    end

    // Write then read back; busy lasts LATENCY cycles per request.
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    wait_idle(1'b1);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    wait_idle(1'b1);
    check("read_0x10", rdata[0], 32'hDEADBEEF);

    // Misaligned write must not touch word 4.
    issue(1'b0, 1'b1, 32'h13, 32'h1234, 4'hF, 1'b0);
    wait_idle(1'b0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    wait_idle(1'b0);
    check("after_misaligned", rdata[2], 32'hDEADBEEF);

    // Conflicting read+write is rejected with rdata cleared.
    issue(1'b1, 1'b1, 32'h10, 32'h9999, 4'hF, 1'b0);
    wait_idle(1'b0);
    check("conflict_rdata", rdata[1], 32'd0);

    // Aliasing: 0x1000 maps onto word 0.
    issue(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 1'b0);
    wait_idle(1'b0);
    issue(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
    wait_idle(1'b0);
    check("alias_read", rdata[0], 32'hA5A5A5A5);

    // Read held for four edges: re-accepted LATENCY+1 edges after each accept.
    @(negedge clk);
    mem_read = 1'b1;
    addr     = 32'h0;
    acc      = cyc + 1;
    expect_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, acc);
    expect_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, acc + 3);
    expect_req(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, acc);
    expect_req(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, acc + 2);
    expect_req(2, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, acc);
    repeat (4) @(posedge clk);
    #1 mem_read = 1'b0;
    wait_idle(1'b0);

    // Reset one cycle after accepting a write: the write is abandoned
    // except on the LATENCY=1 responder, which already committed it.
    issue(1'b0, 1'b1, 32'h20, 32'h77, 4'hF, 1'b0);
    wait_idle(1'b0);
    issue(1'b0, 1'b1, 32'h20, 32'h55, 4'hF, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 3; d++) mdl_rd[d] = 32'd0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("abort_ready[%0d]", d), {31'd0, ready[d]}, 32'd0);
      check($sformatf("abort_busy[%0d]", d), {31'd0, busy[d]}, 32'd0);
    end
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    wait_idle(1'b0);
    check("abort_read_l2", rdata[0], 32'h77);
    check("abort_read_l5", rdata[2], 32'h77);
    check("abort_read_l1", rdata[1], 32'h55);

`ifdef MEM_BYTE_STROBE_EN
    issue(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, 1'b0);
    wait_idle(1'b0);
    issue(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 1'b0);
    wait_idle(1'b0);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
    wait_idle(1'b0);
    check("strobe_read", rdata[0], 32'h11BB33DD);
    issue(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 1'b0);
    wait_idle(1'b0);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
    wait_idle(1'b0);
    check("strobe_noop_read", rdata[2], 32'h11BB33DD);
`endif

    repeat (2) @(negedge clk);
    check("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
